// File: rtl/hangman_pkg.sv
// hangman_pkg: shared definitions for the hangman round controller.
//   state_e  - 4-bit round state encoding
//   cnt_w    - width needed to hold the values 0..max_val
//   sat_inc  - increment that sticks at 2^w-1 (used for the score counters)
package hangman_pkg;

  typedef enum logic [3:0] {
    S_LOAD    = 4'd0,
    S_READY   = 4'd1,
    S_GRAPH   = 4'd2,
    S_GUESS   = 4'd3,
    S_EVAL    = 4'd4,
    S_FILL    = 4'd5,
    S_DRAW    = 4'd6,
    S_WIN     = 4'd7,
    S_LOSE    = 4'd8,
    S_TIMEOUT = 4'd9
  } state_e;

  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (32'd1 << w) - 32'd1;
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/hangman_round_timer.sv
// hangman_round_timer: per-guess time budget.
//   clk, resetn - clock, async active-low reset
//   clr         - restart the budget from zero (wins over en)
//   en          - count this cycle
//   expire      - high while enabled on the last cycle of the budget
module hangman_round_timer #(
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expire = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                cnt_d = '0;
    else if (en && !expire) cnt_d = cnt_q + 1'b1; // park on LAST rather than wrap
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/hangman_round_ctrl.sv
// hangman_round_ctrl: round sequencer for the hangman game.
//   Inputs : keyboard/datapath strobes (char_valid, end_input, start,
//            graph_loaded, guess_valid + match/match_cnt, fill_done,
//            draw_done, wipe) and mode_2p (sampled while loading a word).
//   Outputs: Moore phase enables (wren, ld_g, compare, fill, draw,
//            timecount), terminal flags (win, lose, timed_out), over pulse
//            on wipe, and the round/score counters.
module hangman_round_ctrl
  import hangman_pkg::*;
#(
  parameter int MAX_LEN        = 16,
  parameter int MISS_LIMIT     = 6,
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int SCORE_W        = 4
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           mode_2p,
  input  logic                           char_valid,
  input  logic                           end_input,
  input  logic                           start,
  input  logic                           graph_loaded,
  input  logic                           guess_valid,
  input  logic                           match,
  input  logic [cnt_w(MAX_LEN)-1:0]      match_cnt,
  input  logic                           fill_done,
  input  logic                           draw_done,
  input  logic                           wipe,
  output logic                           wren,
  output logic                           ld_g,
  output logic                           compare,
  output logic                           fill,
  output logic                           draw,
  output logic                           timecount,
  output logic                           over,
  output logic                           win,
  output logic                           lose,
  output logic                           timed_out,
  output logic [cnt_w(MISS_LIMIT)-1:0]   part,
  output logic [cnt_w(MAX_LEN)-1:0]      word_len,
  output logic                           setter,
  output logic [SCORE_W-1:0]             score_p0,
  output logic [SCORE_W-1:0]             score_p1
);

  localparam int LW = cnt_w(MAX_LEN);
  localparam int PW = cnt_w(MISS_LIMIT);
  localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_LEN);
  localparam logic [PW-1:0] PART_MAX = PW'(MISS_LIMIT);

  state_e              state_q, state_d;
  logic [LW-1:0]       word_len_q, word_len_d, revealed_q, revealed_d, mcnt_q, mcnt_d;
  logic [PW-1:0]       part_q, part_d;
  logic                match_q, match_d, mode_q, mode_d, setter_q, setter_d, over_q, over_d;
  logic [SCORE_W-1:0]  score_p0_q, score_p0_d, score_p1_q, score_p1_d;
  logic                run, expire, tmr_clr, win_evt, lose_evt;
  logic [LW:0]         rev_sum;

  assign run     = state_q inside {S_GRAPH, S_GUESS, S_FILL, S_DRAW};
  assign tmr_clr = (state_q == S_READY && start) || (state_q == S_GUESS && guess_valid);

  hangman_round_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk    (clk),
    .resetn (resetn),
    .clr    (tmr_clr),
    .en     (run),
    .expire (expire)
  );

  always_comb begin
    state_d    = state_q;
    word_len_d = word_len_q;
    revealed_d = revealed_q;
    mcnt_d     = mcnt_q;
    match_d    = match_q;
    part_d     = part_q;
    mode_d     = mode_q;
    setter_d   = setter_q;
    score_p0_d = score_p0_q;
    score_p1_d = score_p1_q;
    over_d     = 1'b0;
    win_evt    = 1'b0;
    lose_evt   = 1'b0;
    rev_sum    = {1'b0, revealed_q} + {1'b0, mcnt_q};

    // Expiry beats any done/valid strobe arriving in the same cycle.
    if (expire) begin
      state_d  = S_TIMEOUT;
      lose_evt = 1'b1;
    end else begin
      case (state_q)
        S_LOAD: begin
          mode_d = mode_2p;
          if (char_valid && word_len_q != LEN_MAX) word_len_d = word_len_q + 1'b1;
          if (end_input && word_len_q != '0)       state_d    = S_READY;
        end
        S_READY: if (start)        state_d = S_GRAPH;
        S_GRAPH: if (graph_loaded) state_d = S_GUESS;
        S_GUESS: if (guess_valid) begin
          // Compare result belongs to the guess strobe; hold it for S_EVAL.
          match_d = match;
          mcnt_d  = match_cnt;
          state_d = S_EVAL;
        end
        S_EVAL: begin
          if (match_q && mcnt_q != '0) begin
            revealed_d = (rev_sum > {1'b0, word_len_q}) ? word_len_q : rev_sum[LW-1:0];
            state_d    = S_FILL;
          end else begin
            part_d  = part_q + 1'b1;
            state_d = S_DRAW;
          end
        end
        S_FILL: if (fill_done) begin
          if (revealed_q == word_len_q) begin
            state_d = S_WIN;
            win_evt = 1'b1;
          end else state_d = S_GUESS;
        end
        S_DRAW: if (draw_done) begin
          if (part_q == PART_MAX) begin
            state_d  = S_LOSE;
            lose_evt = 1'b1;
          end else state_d = S_GUESS;
        end
        S_WIN, S_LOSE, S_TIMEOUT: if (wipe) begin
          state_d    = S_LOAD;
          over_d     = 1'b1;
          word_len_d = '0;
          revealed_d = '0;
          part_d     = '0;
          if (mode_q) setter_d = ~setter_q;
        end
        default: state_d = S_LOAD;
      endcase
    end

    // Win credits the guesser (player 1 when player 0 set the word);
    // lose/timeout credits the setter, but only in two-player mode.
    if (win_evt) begin
      if (mode_q && !setter_q) score_p1_d = SCORE_W'(sat_inc(32'(score_p1_q), SCORE_W));
      else                     score_p0_d = SCORE_W'(sat_inc(32'(score_p0_q), SCORE_W));
    end
    if (lose_evt && mode_q) begin
      if (setter_q) score_p1_d = SCORE_W'(sat_inc(32'(score_p1_q), SCORE_W));
      else          score_p0_d = SCORE_W'(sat_inc(32'(score_p0_q), SCORE_W));
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_LOAD;
      word_len_q <= '0;
      revealed_q <= '0;
      mcnt_q     <= '0;
      match_q    <= 1'b0;
      part_q     <= '0;
      mode_q     <= 1'b0;
      setter_q   <= 1'b0;
      over_q     <= 1'b0;
      score_p0_q <= '0;
      score_p1_q <= '0;
    end else begin
      state_q    <= state_d;
      word_len_q <= word_len_d;
      revealed_q <= revealed_d;
      mcnt_q     <= mcnt_d;
      match_q    <= match_d;
      part_q     <= part_d;
      mode_q     <= mode_d;
      setter_q   <= setter_d;
      over_q     <= over_d;
      score_p0_q <= score_p0_d;
      score_p1_q <= score_p1_d;
    end
  end

  assign wren      = (state_q == S_LOAD);
  assign ld_g      = (state_q == S_READY);
  assign compare   = (state_q == S_GUESS);
  assign fill      = (state_q == S_FILL);
  assign draw      = (state_q == S_DRAW);
  assign timecount = run;
  assign over      = over_q;
  assign win       = (state_q == S_WIN);
  assign lose      = (state_q == S_LOSE);
  assign timed_out = (state_q == S_TIMEOUT);
  assign part      = part_q;
  assign word_len  = word_len_q;
  assign setter    = setter_q;
  assign score_p0  = score_p0_q;
  assign score_p1  = score_p1_q;

endmodule

// File: tb/tb_hangman_round_ctrl.sv
// Bench for hangman_round_ctrl: directed rounds, a phase-level model of the
// game compared every cycle, and literal spot checks.
module tb_hangman_round_ctrl;

  localparam int MAXL = 16, MISS = 6, TOC = 20, SW = 4, SMAX = 15;

  logic clk = 1'b0, resetn = 1'b1;
  logic mode_2p = 0, char_valid = 0, end_input = 0, start = 0, graph_loaded = 0;
  logic guess_valid = 0, match = 0, fill_done = 0, draw_done = 0, wipe = 0;
  logic [4:0] match_cnt = '0;
  logic wren, ld_g, compare, fill, draw, timecount, over, win, lose, timed_out, setter;
  logic [2:0] part;
  logic [4:0] word_len;
  logic [3:0] score_p0, score_p1;

  int n_tests = 0, n_fail = 0;

  hangman_round_ctrl #(.MAX_LEN(MAXL), .MISS_LIMIT(MISS), .TIMEOUT_CYCLES(TOC), .SCORE_W(SW)) dut (
    .clk(clk), .resetn(resetn), .mode_2p(mode_2p), .char_valid(char_valid),
    .end_input(end_input), .start(start), .graph_loaded(graph_loaded),
    .guess_valid(guess_valid), .match(match), .match_cnt(match_cnt),
    .fill_done(fill_done), .draw_done(draw_done), .wipe(wipe),
    .wren(wren), .ld_g(ld_g), .compare(compare), .fill(fill), .draw(draw),
    .timecount(timecount), .over(over), .win(win), .lose(lose), .timed_out(timed_out),
    .part(part), .word_len(word_len), .setter(setter), .score_p0(score_p0), .score_p1(score_p1)
  );

  always #5 clk = ~clk;

  // ---------------- game model ----------------
  localparam int P_LOAD = 0, P_READY = 1, P_GRAPH = 2, P_GUESS = 3, P_EVAL = 4,
                 P_FILL = 5, P_DRAW = 6, P_WIN = 7, P_LOSE = 8, P_TO = 9;
  int ph = P_LOAD, m_len = 0, m_rev = 0, m_miss = 0, m_setter = 0, m_s0 = 0, m_s1 = 0;
  int m_over = 0, m_mode = 0, budget = TOC, m_gm = 0, m_gc = 0;

  function automatic bit is_running(int p);
    return p == P_GRAPH || p == P_GUESS || p == P_FILL || p == P_DRAW;
  endfunction

  task automatic award(int who);
    if (who == 0) m_s0 = (m_s0 < SMAX) ? m_s0 + 1 : SMAX;
    else          m_s1 = (m_s1 < SMAX) ? m_s1 + 1 : SMAX;
  endtask

  task automatic model_step();
    m_over = 0;
    if (is_running(ph) && budget == 1) begin
      ph = P_TO;
      if (m_mode != 0) award(m_setter);
    end else begin
      if (is_running(ph)) budget = budget - 1;
      case (ph)
        P_LOAD: begin
          m_mode = int'(mode_2p);
          if (end_input && m_len > 0) ph = P_READY;
          if (char_valid && m_len < MAXL) m_len = m_len + 1;
        end
        P_READY: if (start) begin ph = P_GRAPH; budget = TOC; end
        P_GRAPH: if (graph_loaded) ph = P_GUESS;
        P_GUESS: if (guess_valid) begin
          m_gm = int'(match); m_gc = int'(match_cnt); budget = TOC; ph = P_EVAL;
        end
        P_EVAL: if (m_gm != 0 && m_gc > 0) begin
          m_rev = (m_rev + m_gc > m_len) ? m_len : m_rev + m_gc; ph = P_FILL;
        end else begin
          m_miss = m_miss + 1; ph = P_DRAW;
        end
        P_FILL: if (fill_done) begin
          if (m_rev == m_len) begin ph = P_WIN; award((m_mode != 0) ? 1 - m_setter : 0); end
          else ph = P_GUESS;
        end
        P_DRAW: if (draw_done) begin
          if (m_miss == MISS) begin ph = P_LOSE; if (m_mode != 0) award(m_setter); end
          else ph = P_GUESS;
        end
        default: if (wipe) begin
          ph = P_LOAD; m_over = 1; m_len = 0; m_rev = 0; m_miss = 0;
          if (m_mode != 0) m_setter = 1 - m_setter;
        end
      endcase
    end
  endtask

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ph = P_LOAD; m_len = 0; m_rev = 0; m_miss = 0; m_setter = 0; m_s0 = 0; m_s1 = 0;
      m_over = 0; m_mode = 0; budget = TOC; m_gm = 0; m_gc = 0;
    end else model_step();
  end

  // Per-cycle comparison of every output against the model.
  logic [26:0] exp_v, got_v;
  always @(negedge clk) begin
    exp_v = {ph == P_LOAD, ph == P_READY, ph == P_GUESS, ph == P_FILL, ph == P_DRAW,
             is_running(ph), m_over != 0, ph == P_WIN, ph == P_LOSE, ph == P_TO,
             3'(m_miss), 5'(m_len), m_setter != 0, 4'(m_s0), 4'(m_s1)};
    got_v = {wren, ld_g, compare, fill, draw, timecount, over, win, lose, timed_out,
             part, word_len, setter, score_p0, score_p1};
    n_tests++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL cycle_outputs t=%0t got=%h exp=%h", $time, got_v, exp_v);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic chk(input string nm, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    #2 resetn = 1'b0;
    cyc(2);
    resetn = 1'b1;
  endtask

  task automatic load_word(input int n);
    for (int i = 0; i < n; i++) begin char_valid = 1; cyc(); char_valid = 0; end
  endtask

  task automatic begin_play(input int n);   // leaves the DUT in S_GUESS
    load_word(n);
    end_input = 1;    cyc(); end_input = 0;
    start = 1;        cyc(); start = 0;
    graph_loaded = 1; cyc(); graph_loaded = 0;
  endtask

  task automatic guess(input int m, input int cnt);  // leaves DUT in FILL/DRAW
    match = m[0]; match_cnt = 5'(cnt);
    guess_valid = 1; cyc(); guess_valid = 0;
    cyc();
    match = 0; match_cnt = '0;
  endtask

  task automatic do_fill(); fill_done = 1; cyc(); fill_done = 0; endtask
  task automatic do_draw(); draw_done = 1; cyc(); draw_done = 0; endtask
  task automatic do_wipe(); wipe = 1;      cyc(); wipe = 0;      endtask

  initial begin
    #1 resetn = 1'b0;
    cyc(2);
    resetn = 1'b1;
    chk("rst_wren", int'(wren), 1);
    chk("rst_timecount", int'(timecount), 0);
    chk("rst_word_len", int'(word_len), 0);

    // single-player win: 1+1+2 reveals a 4-letter word
    load_word(4);
    chk("t1_word_len", int'(word_len), 4);
    end_input = 1; cyc(); end_input = 0;
    start = 1; cyc(); start = 0;
    graph_loaded = 1; cyc(); graph_loaded = 0;
    chk("t1_compare", int'(compare), 1);
    guess(1, 1); do_fill();
    guess(1, 1); do_fill();
    chk("t1_not_won_yet", int'(win), 0);
    guess(1, 2); do_fill();
    chk("t1_win", int'(win), 1);
    chk("t1_score_p0", int'(score_p0), 1);
    do_wipe();
    chk("t1_over_pulse", int'(over), 1);
    chk("t1_word_len_clr", int'(word_len), 0);
    cyc();
    chk("t1_over_drop", int'(over), 0);

    // two-player, six misses, setter 0 scores
    do_reset();
    mode_2p = 1;
    begin_play(4);
    for (int i = 1; i <= MISS; i++) begin
      guess(0, 0);
      chk($sformatf("t2_part_%0d", i), int'(part), i);
      do_draw();
    end
    chk("t2_lose", int'(lose), 1);
    chk("t2_score_p0", int'(score_p0), 1);
    chk("t2_score_p1", int'(score_p1), 0);
    do_wipe();
    chk("t2_setter_toggled", int'(setter), 1);
    mode_2p = 0;

    // timeout exactly TOC cycles after S_GRAPH entry; strobes on expiry ignored
    do_reset();
    load_word(2);
    end_input = 1; cyc(); end_input = 0;
    start = 1; cyc(); start = 0;
    graph_loaded = 1; cyc(); graph_loaded = 0;
    cyc(18);
    chk("t3_not_yet", int'(timed_out), 0);
    guess_valid = 1; draw_done = 1; cyc(); guess_valid = 0; draw_done = 0;
    chk("t3_timed_out", int'(timed_out), 1);
    chk("t3_compare_off", int'(compare), 0);
    chk("t3_score_p0", int'(score_p0), 0);

    // word length limits
    do_reset();
    end_input = 1; cyc(); end_input = 0;
    chk("t4_empty_end_ignored", int'(wren), 1);
    load_word(20);
    chk("t4_len_sat", int'(word_len), 16);
    end_input = 1; cyc(); end_input = 0;
    chk("t4_ready", int'(ld_g), 1);

    // two-player setter rotation, then score saturation
    do_reset();
    mode_2p = 1;
    for (int r = 0; r < 3; r++) begin
      chk($sformatf("t5_setter_r%0d", r), int'(setter), r % 2);
      begin_play(1); guess(1, 1); do_fill(); do_wipe();
    end
    chk("t5_setter_end", int'(setter), 1);
    chk("t5_p0", int'(score_p0), 1);
    chk("t5_p1", int'(score_p1), 2);
    mode_2p = 0;
    do_reset();
    for (int r = 0; r < 20; r++) begin
      begin_play(1); guess(1, 1); do_fill(); do_wipe();
    end
    chk("t5_sat", int'(score_p0), SMAX);

    // async reset in the middle of S_DRAW
    begin_play(3);
    guess(0, 0);
    chk("t6_in_draw", int'(draw), 1);
    #2 resetn = 1'b0;
    #1;
    chk("t6_wren", int'(wren), 1);
    chk("t6_draw_off", int'(draw), 0);
    chk("t6_part", int'(part), 0);
    chk("t6_score_p0", int'(score_p0), 0);
    cyc();
    resetn = 1'b1;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
